fetch_prefetch_queue: RTL and testbench
=======================================

# fetch_prefetch_queue

Parametrised instruction-fetch front end that sits between the PC logic and the F/D pipeline register. It replaces fixed-delay branch-stall chains with a request/response handshake to the instruction `mem_system`, an explicit redirect-drain state machine and a DEPTH-entry prefetch FIFO. Decode pops instructions through a valid/ready handshake. Stale cache responses after a branch or jump are discarded by state, not by counting cycles.

## Interface
- `ADDR_W`, 16: PC and address width.
- `INST_W`, 16: instruction width.
- `DEPTH`, 4: prefetch FIFO entries, power of two, ≥ 2.
- `INC`, 2: PC increment per fetched instruction.
- `RESET_PC`, 0: fetch PC after reset.
- `NOP_INST`, 16'h0800: value driven on `inst` when no entry is valid.

- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  ADDR_W  target PC.
- `mem_req_valid`  out  1  fetch request.
- `mem_req_addr`  out  ADDR_W  fetch address (the current fetch PC).
- `mem_req_ready`  in  1  memory accepts the request (`~Stall`).
- `mem_rsp_valid`  in  1  response data valid (`Done`).
- `mem_rsp_data`  in  INST_W  instruction.
- `mem_rsp_err`  in  1  fetch error.
- `inst_valid`  out  1  FIFO head valid.
- `inst`  out  INST_W  head instruction; `NOP_INST` when empty.
- `pc_inc`  out  ADDR_W  head PC + INC.
- `inst_err`  out  1  head entry carries an error.
- `inst_ready`  in  1  decode consumes the head (`~Stall_D`).
- `busy`  out  1  state ≠ IDLE.

## Operation
- Registers:
  - `fetch_pc`: current fetch PC.
  - `req_pc`: PC of the outstanding request.
  - `count`: 0..DEPTH.
  - FIFO head and tail pointers.
  - `state` ∈ {IDLE, WAIT, DRAIN, HALT}.
- At most one outstanding memory request.
- `space` = `count` + (response pushing this cycle) < DEPTH.
- `mem_req_valid` = (IDLE, or WAIT with `mem_rsp_valid` & ~`mem_rsp_err`) & `space` & ~`redirect_valid`.
- On request accept (`mem_req_valid` & `mem_req_ready`):
  - `req_pc` ← `fetch_pc`.
  - `fetch_pc` ← `fetch_pc` + INC, wrapping mod 2^ADDR_W.
  - state → WAIT.
- WAIT with `mem_rsp_valid`, no redirect:
  - Push {data, err, `req_pc` + INC}.
  - If a new request is accepted in the same cycle, stay in WAIT; otherwise go to IDLE.
  - If `mem_rsp_err`, go to HALT instead (no further issue).
- Redirect (highest priority, any state):
  - `fetch_pc` ← `redirect_pc`.
  - FIFO flushed: `count` ← 0, pointers ← 0. Any pop in the same cycle is ignored.
  - WAIT without same-cycle response → DRAIN.
  - WAIT with same-cycle response → IDLE, response discarded.
  - IDLE or HALT → IDLE.
  - DRAIN → DRAIN, latest `redirect_pc` kept.
- DRAIN: no requests; the next `mem_rsp_valid` is discarded, then → IDLE.
- HALT: no requests. FIFO continues to drain to decode. Exit only by redirect or reset.
- Pop on `inst_valid` & `inst_ready`. Simultaneous push and pop leaves `count` unchanged. A push at `count` = DEPTH cannot occur, by construction of `space`.
- `mem_rsp_valid` in IDLE or HALT is a protocol violation; it is ignored.

## Timing
- Reset values:
  - state IDLE, `fetch_pc` = RESET_PC, `count` = 0.
  - `inst_valid` 0, `inst` = NOP_INST, `pc_inc` 0, `inst_err` 0, `busy` 0.
  - `mem_req_valid` 1 in the first cycle after `rst` falls, with `mem_req_addr` = RESET_PC.
- `rst` asserted mid-request: the outstanding response is ignored; the block restarts at RESET_PC.
- Latency:
  - Request accepted at cycle t, response at t+k.
  - `inst_valid` rises at t+k+1 (FIFO output is registered).
- Throughput: with a 1-cycle hit memory and `inst_ready` held high, one instruction per cycle in steady state.
- Redirect in cycle r:
  - `inst_valid` = 0 at r+1.
  - If no request was outstanding, `mem_req_addr` = `redirect_pc` with `mem_req_valid` at r+1.
  - Otherwise the first request issues the cycle after the drained response.
- Outputs depend combinationally only on:
  - registered state, and
  - `mem_rsp_valid`, `mem_rsp_err`, `redirect_valid` for `mem_req_valid`.

## Test plan
- Reset, 1-cycle hit memory, `inst_ready` = 1:
  - requests at 0x0000, 0x0002, 0x0004…
  - `inst`/`pc_inc` pairs (mem[0], 0x0002), (mem[2], 0x0004) on consecutive cycles.
- `inst_ready` = 0 for 10 cycles:
  - `count` saturates at 4.
  - `mem_req_valid` deasserts.
  - No instruction is lost or duplicated when ready returns.
- Redirect to 0x0100 while a 4-cycle miss is outstanding:
  - response discarded;
  - next request at 0x0100;
  - first `inst` has `pc_inc` = 0x0102.
- Redirect in the same cycle as a response and a pop:
  - `inst_valid` = 0 next cycle;
  - no stale entry appears;
  - request at the target the following cycle.
- `mem_rsp_err` on 0x0006:
  - entry delivered with `inst_err` = 1;
  - no further requests;
  - redirect to 0x0020 resumes fetch.
- Address wrap:
  - redirect to 0xFFFE → `pc_inc` = 0x0000, next request at 0x0000.
  - `DEPTH` = 8 and `DEPTH` = 2 runs repeat the back-pressure scenario.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: single-outstanding memory request, redirect/drain
// state machine and a DEPTH-entry prefetch FIFO handing instructions to decode.
module fetch_prefetch_queue #(
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       INST_W   = 16,
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       INC      = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [INST_W-1:0] NOP_INST = 16'h0800
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [INST_W-1:0] mem_rsp_data,
   input  logic              mem_rsp_err,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] pc_inc,
   output logic              inst_err,
   input  logic              inst_ready,
   output logic              busy
);

   localparam int unsigned       PTR_W   = $clog2(DEPTH);
   localparam int unsigned       CNT_W   = PTR_W + 1;
   localparam logic [ADDR_W-1:0] INC_A   = ADDR_W'(INC);
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALT} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PTR_W-1:0]    head_q, head_d;
   logic [PTR_W-1:0]    tail_q, tail_d;

   logic [INST_W-1:0]   data_q  [DEPTH];
   logic [ADDR_W-1:0]   pcinc_q [DEPTH];
   logic [DEPTH-1:0]    err_q;

   logic                not_empty;
   logic                push;
   logic                pop;
   logic                space;
   logic                accept;

   assign not_empty = (count_q != '0);
   assign push      = (state_q == WAIT) && mem_rsp_valid && !redirect_valid;
   assign pop       = not_empty && inst_ready && !redirect_valid;
   // Pops are deliberately not credited, keeping space free of inst_ready.
   assign space     = (count_q + CNT_W'(push)) < DEPTH_C;

   assign mem_req_valid = ((state_q == IDLE) ||
                           ((state_q == WAIT) && mem_rsp_valid && !mem_rsp_err)) &&
                          space && !redirect_valid;
   assign mem_req_addr  = fetch_pc_q;
   assign accept        = mem_req_valid && mem_req_ready;

   assign inst_valid = not_empty;
   assign inst       = not_empty ? data_q[head_q]  : NOP_INST;
   assign pc_inc     = not_empty ? pcinc_q[head_q] : '0;
   assign inst_err   = not_empty && err_q[head_q];
   assign busy       = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         // A response landing with the redirect is the stale one; nothing left to drain.
         unique case (state_q)
            WAIT, DRAIN: state_d = mem_rsp_valid ? IDLE : DRAIN;
            default:     state_d = IDLE;
         endcase
      end else begin
         if (push) tail_d = tail_q + PTR_W'(1);
         if (pop)  head_d = head_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
         unique case (state_q)
            IDLE:    if (accept) state_d = WAIT;
            WAIT:    if (mem_rsp_valid) state_d = mem_rsp_err ? HALT : (accept ? WAIT : IDLE);
            DRAIN:   if (mem_rsp_valid) state_d = IDLE;
            default: state_d = state_q;
         endcase
         if (accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + INC_A;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
      end
   end

   // Payload storage needs no reset; count_q alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[tail_q]  <= mem_rsp_data;
         pcinc_q[tail_q] <= req_pc_q + INC_A;
         err_q[tail_q]   <= mem_rsp_err;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: three instances (DEPTH 4, 2, 8) share stimulus,
// each with its own memory model and expected-instruction scoreboard.
module tb_fetch_prefetch_queue;

   localparam int          NI  = 3;
   localparam logic [15:0] NOP = 16'h0800;

   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] pcInc;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirectValid;
   logic [15:0] redirectPc;
   logic        reqReady;
   logic        instReady;

   logic        reqValid  [NI];
   logic [15:0] reqAddr   [NI];
   logic        rspValid  [NI];
   logic [15:0] rspData   [NI];
   logic        rspErr    [NI];
   logic        instValid [NI];
   logic [15:0] inst      [NI];
   logic [15:0] pcInc     [NI];
   logic        instErr   [NI];
   logic        busy      [NI];

   exp_t        sb [NI][$];
   bit          memBusy [NI];
   int          memCnt  [NI];
   logic [15:0] memAddr [NI];
   int          latency;
   bit          errEn;
   logic [15:0] errAddr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : gDut
      fetch_prefetch_queue #(.DEPTH((g == 1) ? 2 : ((g == 2) ? 8 : 4))) dut (
         .clk           (clk),
         .rst           (rst),
         .redirect_valid(redirectValid),
         .redirect_pc   (redirectPc),
         .mem_req_valid (reqValid[g]),
         .mem_req_addr  (reqAddr[g]),
         .mem_req_ready (reqReady),
         .mem_rsp_valid (rspValid[g]),
         .mem_rsp_data  (rspData[g]),
         .mem_rsp_err   (rspErr[g]),
         .inst_valid    (instValid[g]),
         .inst          (inst[g]),
         .pc_inc        (pcInc[g]),
         .inst_err      (instErr[g]),
         .inst_ready    (instReady),
         .busy          (busy[g])
      );
   end

   function automatic int depthOf(int i);
      return (i == 1) ? 2 : ((i == 2) ? 8 : 4);
   endfunction

   function automatic logic [15:0] memData(logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // Drive this cycle's memory responses and let combinational outputs settle.
   task automatic settle();
      for (int i = 0; i < NI; i++) begin
         rspValid[i] = memBusy[i] && (memCnt[i] == 0);
         rspData[i]  = rspValid[i] ? memData(memAddr[i]) : 16'h0000;
         rspErr[i]   = rspValid[i] && errEn && (memAddr[i] == errAddr);
      end
      #1;
   endtask

   // Score pops, update memory models and scoreboards, then cross the clock edge.
   task automatic advance();
      exp_t e;
      bit   rspNow;
      for (int i = 0; i < NI; i++) begin
         rspNow = rspValid[i];
         if (rst) begin
            sb[i].delete();
            memBusy[i] = 1'b0;
         end else begin
            if (redirectValid) begin
               sb[i].delete();
            end else if (instValid[i] && instReady) begin
               checks++;
               if (sb[i].size() == 0) begin
                  failures++;
                  $display("[TB] FAIL pop_unexpected dut%0d: got inst=%h pc_inc=%h, required no entry",
                           i, inst[i], pcInc[i]);
               end else begin
                  e = sb[i].pop_front();
                  if ({inst[i], pcInc[i], instErr[i]} !== e) begin
                     failures++;
                     $display("[TB] FAIL scoreboard dut%0d: got inst=%h pc_inc=%h err=%b, required inst=%h pc_inc=%h err=%b",
                              i, inst[i], pcInc[i], instErr[i], e.inst, e.pcInc, e.err);
                  end
               end
            end
            if (!instValid[i]) begin
               checks++;
               if (inst[i] !== NOP) begin
                  failures++;
                  $display("[TB] FAIL empty_nop dut%0d: got inst=%h, required %h", i, inst[i], NOP);
               end
            end
            if (rspNow) memBusy[i] = 1'b0;
            else if (memBusy[i]) memCnt[i]--;
            if (reqValid[i] && reqReady) begin
               e.inst  = memData(reqAddr[i]);
               e.pcInc = reqAddr[i] + 16'd2;
               e.err   = errEn && (reqAddr[i] == errAddr);
               sb[i].push_back(e);
               memBusy[i] = 1'b1;
               memCnt[i]  = latency - 1;
               memAddr[i] = reqAddr[i];
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin settle(); advance(); end
      rst = 1'b0;
      settle();
      for (int i = 0; i < NI; i++) begin
         checks += 6;
         if (instValid[i] !== 1'b0) begin failures++; $display("[TB] FAIL reset_inst_valid dut%0d: got %b, required 0", i, instValid[i]); end
         if (inst[i] !== NOP) begin failures++; $display("[TB] FAIL reset_inst dut%0d: got %h, required %h", i, inst[i], NOP); end
         if (pcInc[i] !== 16'h0000) begin failures++; $display("[TB] FAIL reset_pc_inc dut%0d: got %h, required 0000", i, pcInc[i]); end
         if (instErr[i] !== 1'b0) begin failures++; $display("[TB] FAIL reset_inst_err dut%0d: got %b, required 0", i, instErr[i]); end
         if (busy[i] !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy dut%0d: got %b, required 0", i, busy[i]); end
         if (reqValid[i] !== 1'b1 || reqAddr[i] !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_first_req dut%0d: got valid=%b addr=%h, required valid=1 addr=0000", i, reqValid[i], reqAddr[i]);
         end
      end
      advance();
   endtask

   task automatic test_stream();
      for (int k = 1; k <= 6; k++) begin
         settle();
         checks += 2;
         if (reqValid[0] !== 1'b1 || reqAddr[0] !== 16'(2 * k)) begin
            failures++;
            $display("[TB] FAIL stream_req cycle%0d: got valid=%b addr=%h, required valid=1 addr=%h", k, reqValid[0], reqAddr[0], 16'(2 * k));
         end
         if (instValid[0] !== (k >= 2)) begin
            failures++;
            $display("[TB] FAIL stream_inst_valid cycle%0d: got %b, required %b", k, instValid[0], (k >= 2));
         end
         advance();
      end
   endtask

   task automatic test_backpressure();
      instReady = 1'b0;
      repeat (10) begin settle(); advance(); end
      settle();
      for (int i = 0; i < NI; i++) begin
         checks += 3;
         if (reqValid[i] !== 1'b0) begin failures++; $display("[TB] FAIL bp_req_valid dut%0d: got %b, required 0", i, reqValid[i]); end
         if (sb[i].size() != depthOf(i)) begin
            failures++;
            $display("[TB] FAIL bp_fill dut%0d: got %0d entries, required %0d", i, sb[i].size(), depthOf(i));
         end
         if (busy[i] !== 1'b0 || instValid[i] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_state dut%0d: got busy=%b valid=%b, required busy=0 valid=1", i, busy[i], instValid[i]);
         end
      end
      instReady = 1'b1;
      repeat (12) begin settle(); advance(); end
   endtask

   task automatic test_redirect_miss();
      bit found = 1'b0;
      bit got   = 1'b0;
      latency = 4;
      for (int n = 0; n < 40 && !found; n++) begin
         settle();
         if (memBusy[0] && memCnt[0] >= 1) begin
            found = 1'b1;
            redirectValid = 1'b1;
            redirectPc = 16'h0100;
            settle();
         end
         advance();
         redirectValid = 1'b0;
      end
      latency = 1;
      checks++;
      if (!found) begin failures++; $display("[TB] FAIL miss_setup: got no outstanding miss, required one within 40 cycles"); end
      settle();
      checks += 2;
      if (instValid[0] !== 1'b0 || reqValid[0] !== 1'b0) begin
         failures++;
         $display("[TB] FAIL miss_after_redirect: got valid=%b req=%b, required 0 0", instValid[0], reqValid[0]);
      end
      if (busy[0] !== 1'b1) begin failures++; $display("[TB] FAIL miss_drain_busy: got %b, required 1", busy[0]); end
      for (int n = 0; n < 10 && !got; n++) begin
         advance();
         settle();
         if (reqValid[0]) got = 1'b1;
      end
      checks++;
      if (!got || reqAddr[0] !== 16'h0100) begin
         failures++;
         $display("[TB] FAIL miss_target_req: got valid=%b addr=%h, required valid=1 addr=0100", got, reqAddr[0]);
      end
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         advance();
         settle();
         if (instValid[0]) got = 1'b1;
      end
      checks++;
      if (!got || pcInc[0] !== 16'h0102 || inst[0] !== memData(16'h0100)) begin
         failures++;
         $display("[TB] FAIL miss_first_inst: got valid=%b inst=%h pc_inc=%h, required inst=%h pc_inc=0102",
                  got, inst[0], pcInc[0], memData(16'h0100));
      end
      advance();
   endtask

   task automatic test_redirect_rsp_pop();
      bit found = 1'b0;
      repeat (4) begin settle(); advance(); end
      for (int n = 0; n < 20 && !found; n++) begin
         settle();
         if (rspValid[0] && instValid[0] && instReady) begin
            found = 1'b1;
            redirectValid = 1'b1;
            redirectPc = 16'h0040;
            settle();
         end
         advance();
         redirectValid = 1'b0;
      end
      checks++;
      if (!found) begin failures++; $display("[TB] FAIL rsp_pop_setup: got no response+pop cycle, required one within 20 cycles"); end
      settle();
      checks += 2;
      if (instValid[0] !== 1'b0) begin failures++; $display("[TB] FAIL rsp_pop_valid: got %b, required 0", instValid[0]); end
      if (reqValid[0] !== 1'b1 || reqAddr[0] !== 16'h0040) begin
         failures++;
         $display("[TB] FAIL rsp_pop_req: got valid=%b addr=%h, required valid=1 addr=0040", reqValid[0], reqAddr[0]);
      end
      advance(); settle(); advance(); settle();
      checks++;
      if (instValid[0] !== 1'b1 || pcInc[0] !== 16'h0042) begin
         failures++;
         $display("[TB] FAIL rsp_pop_first: got valid=%b pc_inc=%h, required valid=1 pc_inc=0042", instValid[0], pcInc[0]);
      end
      advance();
   endtask

   task automatic test_error();
      bit extraReq = 1'b0;
      bit sawErr   = 1'b0;
      errEn = 1'b1;
      errAddr = 16'h0006;
      redirectValid = 1'b1;
      redirectPc = 16'h0000;
      settle(); advance();
      redirectValid = 1'b0;
      for (int n = 0; n < 15; n++) begin
         settle();
         if (reqValid[0] && reqAddr[0] > 16'h0006) extraReq = 1'b1;
         if (instValid[0] && pcInc[0] == 16'h0008) begin
            sawErr = 1'b1;
            checks++;
            if (instErr[0] !== 1'b1) begin failures++; $display("[TB] FAIL err_flag: got %b, required 1", instErr[0]); end
         end
         advance();
      end
      settle();
      checks += 2;
      if (!sawErr || extraReq) begin
         failures++;
         $display("[TB] FAIL err_halt: got delivered=%b extra_req=%b, required delivered=1 extra_req=0", sawErr, extraReq);
      end
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (reqValid[i] !== 1'b0 || busy[i] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_halt_state dut%0d: got req=%b busy=%b, required req=0 busy=1", i, reqValid[i], busy[i]);
         end
      end
      if (instValid[0] !== 1'b0) begin failures++; $display("[TB] FAIL err_drained: got valid=%b, required 0", instValid[0]); end
      errEn = 1'b0;
      redirectValid = 1'b1;
      redirectPc = 16'h0020;
      settle(); advance();
      redirectValid = 1'b0;
      settle();
      checks++;
      if (reqValid[0] !== 1'b1 || reqAddr[0] !== 16'h0020) begin
         failures++;
         $display("[TB] FAIL err_resume: got valid=%b addr=%h, required valid=1 addr=0020", reqValid[0], reqAddr[0]);
      end
      advance();
      repeat (6) begin settle(); advance(); end
   endtask

   task automatic test_wrap();
      redirectValid = 1'b1;
      redirectPc = 16'hFFFE;
      settle(); advance();
      redirectValid = 1'b0;
      settle();
      checks++;
      if (reqValid[0] !== 1'b1 || reqAddr[0] !== 16'hFFFE) begin
         failures++;
         $display("[TB] FAIL wrap_req0: got valid=%b addr=%h, required valid=1 addr=fffe", reqValid[0], reqAddr[0]);
      end
      advance(); settle();
      checks++;
      if (reqValid[0] !== 1'b1 || reqAddr[0] !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL wrap_req1: got valid=%b addr=%h, required valid=1 addr=0000", reqValid[0], reqAddr[0]);
      end
      advance(); settle();
      checks++;
      if (instValid[0] !== 1'b1 || pcInc[0] !== 16'h0000 || inst[0] !== memData(16'hFFFE)) begin
         failures++;
         $display("[TB] FAIL wrap_inst: got valid=%b inst=%h pc_inc=%h, required valid=1 inst=%h pc_inc=0000",
                  instValid[0], inst[0], pcInc[0], memData(16'hFFFE));
      end
      advance();
      repeat (5) begin settle(); advance(); end
   endtask

   initial begin
      rst = 1'b1;
      redirectValid = 1'b0;
      redirectPc = 16'h0000;
      reqReady = 1'b1;
      instReady = 1'b1;
      latency = 1;
      errEn = 1'b0;
      errAddr = 16'h0006;
      for (int i = 0; i < NI; i++) begin
         memBusy[i] = 1'b0;
         memCnt[i] = 0;
         memAddr[i] = 16'h0000;
         rspValid[i] = 1'b0;
         rspData[i] = 16'h0000;
         rspErr[i] = 1'b0;
      end
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_miss();
      test_redirect_rsp_pop();
      test_error();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion, required finish before 500000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
